// File: rtl/rca_seq_ctrl_if.sv
// rca_seq_ctrl_if
//   Bundles the request handshake, the result handshake and the external
//   RCA slice pins of rca_seq_ctrl.
//   Parameters: N (RCA slice width), K (slices per operation), W = N*K.
//   Request : in_valid, in_ready, in_a[W], in_b[W], in_cin (+ in_sub)
//   Result  : out_valid, out_ready, out_sum[W], out_cout
//   RCA     : rca_a[N], rca_b[N], rca_cin, rca_sum[N], rca_cout
//   Status  : busy
//   Optional macro RCA_SEQ_SUB_EN adds the in_sub request bit.
//   Modport slave is the sequencer side; modport master is the
//   requester / consumer / RCA-datapath side.
interface rca_seq_ctrl_if #(
  parameter int N = 2,
  parameter int K = 4
);
  localparam int W = N * K;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
`ifdef RCA_SEQ_SUB_EN
  logic         in_sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic [N-1:0] rca_a;
  logic [N-1:0] rca_b;
  logic         rca_cin;
  logic [N-1:0] rca_sum;
  logic         rca_cout;
  logic         busy;

  modport slave (
`ifdef RCA_SEQ_SUB_EN
    input  in_sub,
`endif
    input  in_valid, in_a, in_b, in_cin, out_ready, rca_sum, rca_cout,
    output in_ready, out_valid, out_sum, out_cout, rca_a, rca_b, rca_cin, busy
  );

  modport master (
`ifdef RCA_SEQ_SUB_EN
    output in_sub,
`endif
    output in_valid, in_a, in_b, in_cin, out_ready, rca_sum, rca_cout,
    input  in_ready, out_valid, out_sum, out_cout, rca_a, rca_b, rca_cin, busy
  );
endinterface

// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl
//   Performs a W = N*K bit addition by driving one external N-bit
//   ripple-carry adder slice for K consecutive clocks, LSB slice first,
//   feeding each slice carry-out back as the next slice carry-in.
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     bus    : rca_seq_ctrl_if.slave (request/result handshakes, RCA pins,
//              busy)
//   Optional feature: define RCA_SEQ_SUB_EN to add bus.in_sub, which turns
//   the operation into in_a - in_b (b inverted, initial carry forced to 1;
//   out_cout=1 then means no borrow).
module rca_seq_ctrl #(
  parameter int N = 2,
  parameter int K = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  rca_seq_ctrl_if.slave   bus
);
  localparam int W     = N * K;
  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               cout_q, cout_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;

  logic               in_ready_s;
  logic               out_valid_s;
  logic               busy_s;
  logic [N-1:0]       rca_a_s;
  logic [N-1:0]       rca_b_s;
  logic               rca_cin_s;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    a_d         = a_q;
    b_d         = b_q;
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    busy_s      = 1'b0;
    rca_a_s     = '0;
    rca_b_s     = '0;
    rca_cin_s   = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready_s = 1'b1;
        if (bus.in_valid) begin
          a_d   = bus.in_a;
          idx_d = '0;
`ifdef RCA_SEQ_SUB_EN
          // Subtraction is a + ~b + 1; the request carry is irrelevant then.
          b_d     = bus.in_sub ? ~bus.in_b : bus.in_b;
          carry_d = bus.in_sub ? 1'b1 : bus.in_cin;
`else
          b_d     = bus.in_b;
          carry_d = bus.in_cin;
`endif
          state_d = RUN;
        end
      end

      RUN: begin
        busy_s    = 1'b1;
        rca_cin_s = carry_q;
        // Decoded slice select keeps every index constant and in range.
        for (int k = 0; k < K; k++) begin
          if (idx_q == IDX_W'(k)) begin
            rca_a_s             = a_q[k*N +: N];
            rca_b_s             = b_q[k*N +: N];
            sum_d[k*N +: N]     = bus.rca_sum;
          end
        end
        carry_d = bus.rca_cout;
        if (idx_q == IDX_W'(K - 1)) begin
          cout_d  = bus.rca_cout;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DONE: begin
        busy_s      = 1'b1;
        out_valid_s = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Operand registers are only observed in RUN, after a load, so they need
  // no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.busy      = busy_s;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign bus.rca_a     = rca_a_s;
  assign bus.rca_b     = rca_b_s;
  assign bus.rca_cin   = rca_cin_s;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// tb_rca_seq_ctrl
//   Bench for rca_seq_ctrl with N=2, K=4. Supplies a behavioural RCA slice,
//   keeps a transaction-level model of the sequencer (accepted operands,
//   cycles remaining, expected wide result) and compares every cycle, plus
//   directed scenarios with literal expectations.
module tb_rca_seq_ctrl;
  localparam int N = 2;
  localparam int K = 4;
  localparam int W = N * K;

  logic clk;
  logic rst_n;

  rca_seq_ctrl_if #(.N(N), .K(K)) bus ();

  rca_seq_ctrl #(.N(N), .K(K)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External combinational RCA slice.
  assign {bus.rca_cout, bus.rca_sum} = {1'b0, bus.rca_a} + {1'b0, bus.rca_b}
                                     + {{N{1'b0}}, bus.rca_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [W-1:0] m_a, m_beff;
  logic         m_c0;
  logic [W:0]   m_exp;
  int           m_left;   // RUN cycles still to go
  bit           m_done;   // result being offered
  int           cyc;
  int           acc_q[$]; // cycle numbers of accepted requests

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_exp  <= '0;
    end else begin
      cyc <= cyc + 1;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) m_done <= 1'b1;
      end else if (m_done) begin
        if (bus.out_ready) m_done <= 1'b0;
      end else if (bus.in_valid) begin
        logic [W-1:0] be;
        logic         c0;
        be = bus.in_b;
        c0 = bus.in_cin;
`ifdef RCA_SEQ_SUB_EN
        if (bus.in_sub) begin
          be = ~bus.in_b;
          c0 = 1'b1;
        end
`endif
        m_a    <= bus.in_a;
        m_beff <= be;
        m_c0   <= c0;
        m_exp  <= {1'b0, bus.in_a} + {1'b0, be} + {{W{1'b0}}, c0};
        m_left <= K;
        acc_q.push_back(cyc);
      end
    end
  end

  initial cyc = 0;

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      bit idle, run;
      idle = (m_left == 0) && !m_done;
      run  = (m_left > 0);
      chk("in_ready", 64'(bus.in_ready), 64'(idle));
      chk("busy", 64'(bus.busy), 64'(!idle));
      chk("out_valid", 64'(bus.out_valid), 64'(m_done));
      if (run) begin
        int j;
        longint low, ea, eb, ec;
        j   = K - m_left;
        low = (longint'(1) << (j * N)) - 1;
        ea  = (longint'(m_a) >> (j * N)) & ((longint'(1) << N) - 1);
        eb  = (longint'(m_beff) >> (j * N)) & ((longint'(1) << N) - 1);
        ec  = (((longint'(m_a) & low) + (longint'(m_beff) & low) + longint'(m_c0)) >> (j * N)) & 1;
        chk("rca_a", 64'(bus.rca_a), 64'(ea));
        chk("rca_b", 64'(bus.rca_b), 64'(eb));
        chk("rca_cin", 64'(bus.rca_cin), 64'(ec));
      end else begin
        chk("rca_a_zero", 64'(bus.rca_a), 64'd0);
        chk("rca_b_zero", 64'(bus.rca_b), 64'd0);
        chk("rca_cin_zero", 64'(bus.rca_cin), 64'd0);
      end
      if (m_done) begin
        chk("out_sum", 64'(bus.out_sum), 64'(m_exp[W-1:0]));
        chk("out_cout", 64'(bus.out_cout), 64'(m_exp[W]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
`ifdef RCA_SEQ_SUB_EN
    bus.in_sub   = sub;
`endif
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  logic rcin_seq [4];

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
`ifdef RCA_SEQ_SUB_EN
    bus.in_sub    = 1'b0;
`endif
    bus.out_ready = 1'b0;
    step();
    step();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_sum", 64'(bus.out_sum), 64'd0);
    chk("rst_out_cout", 64'(bus.out_cout), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_rca_a", 64'(bus.rca_a), 64'd0);
    chk("rst_rca_cin", 64'(bus.rca_cin), 64'd0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // 0xFF + 0x01: full carry ripple through all slices.
    request(8'hFF, 8'h01, 1'b0, 1'b0);
    for (int j = 0; j < K; j++) begin
      rcin_seq[j] = bus.rca_cin;
      step();
    end
    chk("t1_cin0", 64'(rcin_seq[0]), 64'd0);
    chk("t1_cin1", 64'(rcin_seq[1]), 64'd1);
    chk("t1_cin2", 64'(rcin_seq[2]), 64'd1);
    chk("t1_cin3", 64'(rcin_seq[3]), 64'd1);
    chk("t1_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_sum", 64'(bus.out_sum), 64'h00);
    chk("t1_cout", 64'(bus.out_cout), 64'd1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // 0x3C + 0x5A + 1 with back-pressure.
    request(8'h3C, 8'h5A, 1'b1, 1'b0);
    repeat (K) step();
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", 64'(bus.out_valid), 64'd1);
      chk("t2_hold_sum", 64'(bus.out_sum), 64'h97);
      chk("t2_hold_cout", 64'(bus.out_cout), 64'd0);
      chk("t2_hold_ready", 64'(bus.in_ready), 64'd0);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    chk("t2_consumed", 64'(bus.out_valid), 64'd0);
    chk("t2_ready_back", 64'(bus.in_ready), 64'd1);
    chk("t2_sum_kept", 64'(bus.out_sum), 64'h97);

    // Continuous in_valid with a new operand pair every cycle.
    acc_q.delete();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_a   = 8'(i * 37 + 5);
      bus.in_b   = 8'(i * 91 + 200);
      bus.in_cin = 1'(i);
      step();
    end
    bus.in_valid = 1'b0;
    repeat (K + 2) step();
    chk("t3_accepts", 64'(acc_q.size()), 64'd4);
    for (int i = 1; i < acc_q.size(); i++)
      chk("t3_interval", 64'(acc_q[i] - acc_q[i-1]), 64'(K + 2));
    bus.out_ready = 1'b0;

    // Reset pulse during the second RUN cycle.
    request(8'hAA, 8'h55, 1'b1, 1'b0);
    step();
    rst_n = 1'b0;
    #2;
    chk("t4_valid", 64'(bus.out_valid), 64'd0);
    chk("t4_busy", 64'(bus.busy), 64'd0);
    chk("t4_sum", 64'(bus.out_sum), 64'd0);
    chk("t4_cout", 64'(bus.out_cout), 64'd0);
    chk("t4_rca_a", 64'(bus.rca_a), 64'd0);
    chk("t4_rca_b", 64'(bus.rca_b), 64'd0);
    chk("t4_rca_cin", 64'(bus.rca_cin), 64'd0);
    rst_n = 1'b1;
    step();
    chk("t4_in_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      chk("t4_no_result", 64'(bus.out_valid), 64'd0);
      step();
    end
    request(8'h10, 8'h20, 1'b0, 1'b0);
    repeat (K) step();
    chk("t4_next_valid", 64'(bus.out_valid), 64'd1);
    chk("t4_next_sum", 64'(bus.out_sum), 64'h30);
    chk("t4_next_cout", 64'(bus.out_cout), 64'd0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

`ifdef RCA_SEQ_SUB_EN
    request(8'h05, 8'h07, 1'b0, 1'b1);
    repeat (K) step();
    chk("sub_sum", 64'(bus.out_sum), 64'hFE);
    chk("sub_cout", 64'(bus.out_cout), 64'd0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    request(8'h07, 8'h05, 1'b1, 1'b1);
    repeat (K) step();
    chk("sub2_sum", 64'(bus.out_sum), 64'h02);
    chk("sub2_cout", 64'(bus.out_cout), 64'd1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
